// File: rtl/msrv32_lsu.sv
// msrv32 load/store unit: one data-memory access per op over a req/ack bus.
// Formats load data, replicates store lanes, flags misaligned/illegal/timeout.
module msrv32_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        is_load_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        fault_out,
    output logic [31:0] load_data_out,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_wstrb_out,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rdata_in
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic        r_is_load;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_addr, r_wdata, r_load_data;
    logic [3:0]  r_wstrb;

    logic        w_bad, w_timeout;
    logic [31:0] w_wdata, w_fmt;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_bad = 1'b0;
        if (is_load_in)
            w_bad = (funct3_in == 3'b011) || (funct3_in[2:1] == 2'b11);
        else
            w_bad = (funct3_in >= 3'b011);
        if (funct3_in[1:0] == 2'b01 && addr_in[0])
            w_bad = 1'b1;
        if (funct3_in[1:0] == 2'b10 && addr_in[1:0] != 2'b00)
            w_bad = 1'b1;
    end

    always_comb begin
        w_wdata = store_data_in;
        w_wstrb = 4'b1111;
        unique case (funct3_in[1:0])
            2'b00: begin
                w_wdata = {4{store_data_in[7:0]}};
                w_wstrb = 4'b0001 << addr_in[1:0];
            end
            2'b01: begin
                w_wdata = {2{store_data_in[15:0]}};
                w_wstrb = 4'b0011 << addr_in[1:0];
            end
            default: ;
        endcase
        if (is_load_in)
            w_wstrb = 4'b0000;
    end

    assign w_byte = dmem_rdata_in[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];

    always_comb begin
        w_fmt = dmem_rdata_in;
        unique case (r_funct3)
            3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_fmt = {24'b0, w_byte};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b101:  w_fmt = {16'b0, w_half};
            default: ;
        endcase
    end

    assign w_timeout = ({1'b0, r_cnt} + 17'd1) >= 17'(TIMEOUT_CYCLES);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:
                if (start_in)
                    w_next = w_bad ? FAULT : REQ;
            REQ:
                if (dmem_ack_in)
                    w_next = RESP;
                else if (w_timeout)
                    w_next = FAULT;
            RESP:  w_next = IDLE;
            FAULT: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_is_load   <= 1'b0;
            r_funct3    <= '0;
            r_off       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_load_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start_in) begin
                r_cnt     <= '0;
                r_is_load <= is_load_in;
                r_funct3  <= funct3_in;
                r_off     <= addr_in[1:0];
                r_addr    <= {addr_in[31:2], 2'b00};
                r_wdata   <= w_wdata;
                r_wstrb   <= w_wstrb;
            end else if (r_state == REQ && !dmem_ack_in) begin
                r_cnt <= r_cnt + 16'd1;
            end
            // Load result is captured on the ack edge, not in RESP.
            if (r_state == REQ && dmem_ack_in && r_is_load)
                r_load_data <= w_fmt;
        end
    end

    assign busy_out       = (r_state != IDLE);
    assign done_out       = (r_state == RESP);
    assign fault_out      = (r_state == FAULT);
    assign dmem_req_out   = (r_state == REQ);
    assign dmem_we_out    = (r_state == REQ) && !r_is_load;
    assign dmem_addr_out  = r_addr;
    assign dmem_wdata_out = r_wdata;
    assign dmem_wstrb_out = r_wstrb;
    assign load_data_out  = r_load_data;

endmodule

// File: tb/tb_msrv32_lsu.sv
// Randomized bench for msrv32_lsu: per-cycle expectations from a
// transaction-level model, compared on the falling edge.
module tb_msrv32_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] sdata = '0;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;

    logic        busy_out, done_out, fault_out;
    logic [31:0] load_data_out;
    logic        dmem_req_out, dmem_we_out;
    logic [31:0] dmem_addr_out, dmem_wdata_out;
    logic [3:0]  dmem_wstrb_out;

    msrv32_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .start_in(start),
        .is_load_in(is_load),
        .funct3_in(f3),
        .addr_in(addr),
        .store_data_in(sdata),
        .busy_out(busy_out),
        .done_out(done_out),
        .fault_out(fault_out),
        .load_data_out(load_data_out),
        .dmem_req_out(dmem_req_out),
        .dmem_we_out(dmem_we_out),
        .dmem_addr_out(dmem_addr_out),
        .dmem_wdata_out(dmem_wdata_out),
        .dmem_wstrb_out(dmem_wstrb_out),
        .dmem_ack_in(ack),
        .dmem_rdata_in(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy, done, fault, req, we;
        logic [31:0] addr, wdata;
        logic [3:0]  strb;
        logic [31:0] ld;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_ld = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic b, d, f, r, w,
                                input logic [31:0] a, wd,
                                input logic [3:0] s,
                                input logic [31:0] l);
        exp_t e;
        e.busy = b; e.done = d; e.fault = f; e.req = r; e.we = w;
        e.addr = a; e.wdata = wd; e.strb = s; e.ld = l;
        return e;
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] fn,
                                             input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * off)) & 32'hFF;
        h = (rd >> (16 * (off / 2))) & 32'hFFFF;
        case (fn)
            3'd0: return (b >= 128) ? b - 32'd256 : b;
            3'd4: return b;
            3'd1: return (h >= 32768) ? h - 32'd65536 : h;
            3'd5: return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] st_wdata(input logic [2:0] fn,
                                             input logic [31:0] sd);
        if (fn == 3'd0) return (sd & 32'hFF) * 32'h01010101;
        if (fn == 3'd1) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [3:0] st_strb(input logic [2:0] fn,
                                           input logic [1:0] off);
        if (fn == 3'd0) return 4'(1 << off);
        if (fn == 3'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic bit legal(input bit ld, input logic [2:0] fn,
                                 input logic [31:0] a);
        int sz;
        bit ok;
        sz = (fn[1:0] == 2'd0) ? 1 : (fn[1:0] == 2'd1) ? 2 : 4;
        ok = ld ? (fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (fn <= 3'd2);
        return ok && ((a % sz) == 0);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("busy", 32'(busy_out), 32'(e.busy));
            chk("done", 32'(done_out), 32'(e.done));
            chk("fault", 32'(fault_out), 32'(e.fault));
            chk("req", 32'(dmem_req_out), 32'(e.req));
            chk("load_data", load_data_out, e.ld);
            if (e.req) begin
                chk("we", 32'(dmem_we_out), 32'(e.we));
                chk("addr", dmem_addr_out, e.addr);
                chk("strb", 32'(dmem_wstrb_out), 32'(e.strb));
                if (e.we) chk("wdata", dmem_wdata_out, e.wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input bit ld, input logic [2:0] fn,
                         input logic [31:0] a, sd, rd,
                         input int wt, input bit hold, spur);
        logic [31:0] ba, wd;
        logic [3:0]  sb;
        ba = a & ~32'h3;
        wd = st_wdata(fn, sd);
        sb = ld ? 4'h0 : st_strb(fn, a[1:0]);
        tick();
        start = 1'b1; is_load = ld; f3 = fn; addr = a; sdata = sd; ack = 1'b0;
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, m_ld));
        if (!legal(ld, fn, a)) begin
            tick();
            start = hold; addr = $urandom; f3 = 3'($urandom);
            q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, m_ld));
        end else begin
            for (int k = 0; k < TO; k++) begin
                tick();
                start = hold; addr = $urandom; sdata = $urandom;
                ack = (k == wt);
                rdata = ack ? rd : $urandom;
                q.push_back(mk(1, 0, 0, 1, !ld, ba, wd, sb, m_ld));
                if (ack) break;
            end
            tick();
            start = hold; ack = 1'b0; rdata = $urandom;
            if (wt < TO) begin
                if (ld) m_ld = fmt_load(fn, a[1:0], rd);
                q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, m_ld));
            end else begin
                q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, m_ld));
            end
        end
        tick();
        start = 1'b0; ack = spur; rdata = $urandom;
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, m_ld));
        tick();
        ack = 1'b0;
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, m_ld));
    endtask

    initial begin
        logic [31:0] a, rd;
        logic [2:0]  fn;
        bit          ld;

        #12;
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_req", 32'(dmem_req_out), 0);
        chk("rst_done", 32'(done_out), 0);
        chk("rst_fault", 32'(fault_out), 0);
        chk("rst_ld", load_data_out, 0);
        chk("rst_strb", 32'(dmem_wstrb_out), 0);
        rst_n = 1'b1;

        chk("model_lb", fmt_load(3'd0, 2'd3, 32'h80FF1234), 32'hFFFFFF80);
        chk("model_lhu", fmt_load(3'd5, 2'd2, 32'h80FF1234), 32'h000080FF);
        chk("model_sh_wd", st_wdata(3'd1, 32'h1234ABCD), 32'hABCDABCD);
        chk("model_sh_sb", 32'(st_strb(3'd1, 2'd2)), 32'hC);

        do_op(1, 3'd0, 32'h1003, 0, 32'h80FF1234, 0, 0, 0);
        chk("lb_lit", load_data_out, 32'hFFFFFF80);
        do_op(1, 3'd4, 32'h1003, 0, 32'h80FF1234, 0, 0, 0);
        chk("lbu_lit", load_data_out, 32'h00000080);
        do_op(0, 3'd1, 32'h2002, 32'h1234ABCD, 0, 3, 0, 0);
        chk("sh_keep_ld", load_data_out, 32'h00000080);
        do_op(1, 3'd2, 32'h0006, 0, 0, 0, 0, 0);
        do_op(0, 3'd3, 32'h0000, 32'h55, 0, 0, 0, 0);
        do_op(1, 3'd2, 32'h0040, 0, 32'h1111, 9, 0, 0);
        chk("to_keep_ld", load_data_out, 32'h00000080);
        do_op(1, 3'd2, 32'h0080, 0, 32'hCAFEF00D, 2, 1, 1);
        chk("hold_lw", load_data_out, 32'hCAFEF00D);

        tick();
        start = 1'b1; is_load = 1'b1; f3 = 3'd2; addr = 32'h100;
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, m_ld));
        tick();
        start = 1'b0;
        q.push_back(mk(1, 0, 0, 1, 0, 32'h100, 0, 4'h0, m_ld));
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(dmem_req_out), 0);
        chk("arst_busy", 32'(busy_out), 0);
        chk("arst_ld", load_data_out, 0);
        chk("arst_done", 32'(done_out), 0);
        m_ld = '0;
        #3 rst_n = 1'b1;
        do_op(1, 3'd2, 32'h0, 0, 32'h0BADBEEF, 1, 0, 0);
        chk("post_rst_lw", load_data_out, 32'h0BADBEEF);

        for (int i = 0; i < 250; i++) begin
            ld = 1'($urandom);
            fn = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            rd = $urandom;
            do_op(ld, fn, a, $urandom, rd, $urandom_range(0, 5),
                  1'($urandom), 1'($urandom));
        end

        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
